cp_dmem_port_master: RTL

- Client-side controller that drives the CP cluster data memory: two read ports (A, B) for operand fetch and one write port (C) for result write-back.
- Turns operand-fetch requests into address cycles and absorbs the memory's 1-cycle registered read latency.
- Buffers returned operand pairs behind a valid/ready handshake to the CP datapath, and serialises write-back without read/write collisions.

---
 rtl/cp_dmem_pkg.sv | 19 +
 rtl/cp_opd_fifo.sv | 65 ++++++
 rtl/cp_dmem_port_master.sv | 116 +++++++++++
 3 files changed

// File: rtl/cp_dmem_pkg.sv
// Shared constants and types for the CP data-memory port master.
package cp_dmem_pkg;

    // Default datapath / memory word width.
    localparam int CP_D_WIDTH_DEFAULT      = 72;
    // Default data-memory address width.
    localparam int DMEM_ADDR_WIDTH_DEFAULT = 10;
    // Operand buffer depth; must be a power of two and at least 4.
    localparam int OPD_FIFO_DEPTH          = 4;
    // Width of the FIFO occupancy counter (holds 0..OPD_FIFO_DEPTH).
    localparam int OPD_CNT_WIDTH           = $clog2(OPD_FIFO_DEPTH) + 1;

    // One returned operand pair; a occupies the upper half when packed.
    typedef struct packed {
        logic [CP_D_WIDTH_DEFAULT-1:0] a;
        logic [CP_D_WIDTH_DEFAULT-1:0] b;
    } opd_pair_t;

endpackage

// File: rtl/cp_opd_fifo.sv
// Show-ahead synchronous FIFO that buffers returned operand pairs.
// The head entry is always visible on head_data; a pop only advances it.
module cp_opd_fifo
    import cp_dmem_pkg::*;
#(
    parameter int WIDTH = 2 * CP_D_WIDTH_DEFAULT,
    parameter int DEPTH = OPD_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    // A pop on an empty FIFO is ignored so the pointers never run ahead.
    assign do_pop = pop && (count != '0);

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The credit scheme upstream guarantees a push never lands on a full FIFO.
    always_ff @(posedge clock) begin
        if (nreset) begin
            assert (!(push && (count == FULL_COUNT) && !do_pop));
        end
    end

    assign head_data = mem[rd_ptr];
    assign not_empty = (count != '0);

endmodule

// File: rtl/cp_dmem_port_master.sv
// Client-side controller for the CP cluster data memory: two read ports
// fetch operand pairs through a 2-stage pipe into a credit-protected FIFO,
// and a third port performs single-cycle write-back.
//
// Handshakes: every interface uses valid/ready; a transfer happens on a
// rising clock edge where valid and ready are both high. valid does not
// depend on ready; ready may depend on valid-side payload only through the
// read/write address collision check.
module cp_dmem_port_master
    import cp_dmem_pkg::*;
#(
    parameter int CP_D_WIDTH      = CP_D_WIDTH_DEFAULT,
    parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr_a,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr_b,
    output logic                       opd_valid,
    input  logic                       opd_ready,
    output logic [CP_D_WIDTH-1:0]      opd_a,
    output logic [CP_D_WIDTH-1:0]      opd_b,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [DMEM_ADDR_WIDTH-1:0] wb_addr,
    input  logic [CP_D_WIDTH-1:0]      wb_data,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_a,
    input  logic [CP_D_WIDTH-1:0]      dmem_out_a,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_b,
    input  logic [CP_D_WIDTH-1:0]      dmem_out_b,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_c,
    output logic [CP_D_WIDTH-1:0]      dmem_in_c,
    output logic                       dmem_we_c
);

    localparam int CW = OPD_CNT_WIDTH;

    logic                    stage1_valid;
    logic                    stage2_valid;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             occupancy;
    logic                    credit_ok;
    logic                    collide;
    logic                    req_fire;
    logic                    wb_fire;
    logic                    opd_pop;
    logic [2*CP_D_WIDTH-1:0] head_data;

    // A write to an address being read this cycle would race the memory's
    // read sampling, so the read waits one cycle and then sees the new data.
    assign collide = wb_valid && ((wb_addr == req_addr_a) || (wb_addr == req_addr_b));

    // Reserve a FIFO slot for every read still in the pipe so it can never overflow.
    assign occupancy = {1'b0, fifo_count}
                     + {{CW{1'b0}}, stage1_valid}
                     + {{CW{1'b0}}, stage2_valid};
    assign credit_ok = occupancy < (CW + 1)'(OPD_FIFO_DEPTH);

    assign req_ready = nreset && credit_ok && !collide;
    assign req_fire  = req_valid && req_ready;
    assign wb_ready  = nreset;
    assign wb_fire   = wb_valid && wb_ready;
    assign opd_pop   = opd_valid && opd_ready;

    // Read address pipe: launch addresses on accept and track the two in-flight stages.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            dmem_addr_a  <= '0;
            dmem_addr_b  <= '0;
            stage1_valid <= 1'b0;
            stage2_valid <= 1'b0;
        end else begin
            if (req_fire) begin
                dmem_addr_a <= req_addr_a;
                dmem_addr_b <= req_addr_b;
            end
            stage1_valid <= req_fire;
            stage2_valid <= stage1_valid;
        end
    end

    // Write-back register: one write-enable pulse per accepted write.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            dmem_addr_c <= '0;
            dmem_in_c   <= '0;
            dmem_we_c   <= 1'b0;
        end else begin
            dmem_we_c <= wb_fire;
            if (wb_fire) begin
                dmem_addr_c <= wb_addr;
                dmem_in_c   <= wb_data;
            end
        end
    end

    cp_opd_fifo #(
        .WIDTH (2 * CP_D_WIDTH),
        .DEPTH (OPD_FIFO_DEPTH)
    ) u_opd_fifo (
        .clock     (clock),
        .nreset    (nreset),
        .push      (stage2_valid),
        .push_data ({dmem_out_a, dmem_out_b}),
        .pop       (opd_pop),
        .head_data (head_data),
        .not_empty (opd_valid),
        .count     (fifo_count)
    );

    assign opd_a = head_data[2*CP_D_WIDTH-1:CP_D_WIDTH];
    assign opd_b = head_data[CP_D_WIDTH-1:0];

endmodule
